// File: rtl/rv32i_writeback_arbiter_pkg.sv
// Shared widths, entry layout and address helpers for the RV32I writeback arbiter.
package rv32i_writeback_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int ENTRY_W    = REG_ADDR_W + XLEN;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_FIFO
  } wb_src_e;

  // RV32E only has x0..x15, so the top address bit is forced low.
  function automatic logic [REG_ADDR_W-1:0] mask_reg(input logic [REG_ADDR_W-1:0] addr,
                                                     input int reg_num);
    logic [REG_ADDR_W-1:0] m;
    m = addr;
    if (reg_num == 16) m[REG_ADDR_W-1] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/rv32i_wb_fifo.sv
// Small synchronous FIFO for long-latency results; pointers carry one extra
// wrap bit so full and empty are told apart by comparing the MSBs.
module rv32i_wb_fifo
  import rv32i_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rv32i_writeback_arbiter.sv
// Merges ALU and long-latency results onto the single register-file write port,
// tracks pending long-latency destinations and offers same-cycle bypass.
module rv32i_writeback_arbiter
  import rv32i_writeback_arbiter_pkg::*;
#(
  parameter int REG_NUM    = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic        pend_set,
  input  logic [4:0]  pend_rd,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  output logic        hazard_stall,
  output logic        rs1_fwd_valid,
  output logic [31:0] rs1_fwd_data,
  output logic        rs2_fwd_valid,
  output logic [31:0] rs2_fwd_data,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_we,
  output logic        busy
);

  logic [4:0]  alu_rd_m, lsu_rd_m, pend_rd_m, rs1_m, rs2_m, drd_m;
  logic [31:0] pending, pending_next;
  wb_entry_t   push_entry, head, sel;
  wb_src_e     src;
  logic        fifo_full, fifo_empty, push, pop;

  assign alu_rd_m  = mask_reg(alu_rd, REG_NUM);
  assign lsu_rd_m  = mask_reg(lsu_rd, REG_NUM);
  assign pend_rd_m = mask_reg(pend_rd, REG_NUM);
  assign rs1_m     = mask_reg(dec_rs1, REG_NUM);
  assign rs2_m     = mask_reg(dec_rs2, REG_NUM);
  assign drd_m     = mask_reg(dec_rd, REG_NUM);

  // Ready comes only from registered occupancy, so a drain cannot open a slot early.
  assign lsu_ready       = !fifo_full;
  assign push            = lsu_valid && !fifo_full;
  assign push_entry.rd   = lsu_rd_m;
  assign push_entry.data = lsu_data;

  rv32i_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ALU results own the write slot; the FIFO head only drains in idle ALU cycles.
  always_comb begin
    src = SRC_NONE;
    sel = '0;
    if (alu_valid) begin
      src      = SRC_ALU;
      sel.rd   = alu_rd_m;
      sel.data = alu_data;
    end else if (!fifo_empty) begin
      src = SRC_FIFO;
      sel = head;
    end
  end

  assign pop = (src == SRC_FIFO);

  // Clear first, then set, so a new issue to the same register survives the drain.
  always_comb begin
    pending_next = pending;
    if (pop) pending_next[head.rd] = 1'b0;
    if (pend_set && (pend_rd_m != '0)) pending_next[pend_rd_m] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      rd_we   <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else begin
      pending <= pending_next;
      rd_we   <= (src != SRC_NONE) && (sel.rd != '0);
      if (src != SRC_NONE) begin
        rd_addr <= sel.rd;
        rd_data <= sel.data;
      end
    end
  end

  assign hazard_stall = ((rs1_m != '0) && pending[rs1_m]) ||
                        ((rs2_m != '0) && pending[rs2_m]) ||
                        ((drd_m != '0) && pending[drd_m]);

  assign rs1_fwd_valid = rd_we && (rd_addr == rs1_m) && (rs1_m != '0);
  assign rs1_fwd_data  = rs1_fwd_valid ? rd_data : '0;
  assign rs2_fwd_valid = rd_we && (rd_addr == rs2_m) && (rs2_m != '0);
  assign rs2_fwd_data  = rs2_fwd_valid ? rd_data : '0;

  assign busy = !fifo_empty || (pending != '0);

endmodule

// File: tb/tb_rv32i_writeback_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic, all compared against a queue-based transaction model.
module tb_rv32i_writeback_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid, pend_set;
  logic [4:0]  alu_rd, lsu_rd, pend_rd, dec_rs1, dec_rs2, dec_rd;
  logic [31:0] alu_data, lsu_data;
  logic        lsu_ready, hazard_stall, rs1_fwd_valid, rs2_fwd_valid, rd_we, busy;
  logic [31:0] rs1_fwd_data, rs2_fwd_data, rd_data;
  logic [4:0]  rd_addr;

  always #5 clk = ~clk;

  rv32i_writeback_arbiter #(.REG_NUM(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .pend_set(pend_set), .pend_rd(pend_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .hazard_stall(hazard_stall),
    .rs1_fwd_valid(rs1_fwd_valid), .rs1_fwd_data(rs1_fwd_data),
    .rs2_fwd_valid(rs2_fwd_valid), .rs2_fwd_data(rs2_fwd_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we), .busy(busy)
  );

  typedef struct {
    logic        av; logic [4:0] ar; logic [31:0] ad;
    logic        lv; logic [4:0] lr; logic [31:0] ld;
    logic        ps; logic [4:0] pr;
    logic [4:0]  rs1, rs2, drd;
  } stim_t;

  typedef struct {
    stim_t       in;
    logic        we; logic [4:0] addr; logic [31:0] data;
    logic        ready, stall, f1v; logic [31:0] f1d; logic f2v, busy;
  } vec_t;

  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: queue of accepted results, pending flags, last write.
  ent_t        m_q[$];
  bit          m_pend[32];
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [4:0]  wr_log[$];

  vec_t tbl[18];

  function automatic stim_t st(bit av, logic [4:0] ar, logic [31:0] ad, bit lv, logic [4:0] lr,
                               logic [31:0] ld, bit ps, logic [4:0] pr, logic [4:0] rs1,
                               logic [4:0] rs2, logic [4:0] drd);
    stim_t s;
    s.av = av; s.ar = ar; s.ad = ad; s.lv = lv; s.lr = lr; s.ld = ld;
    s.ps = ps; s.pr = pr; s.rs1 = rs1; s.rs2 = rs2; s.drd = drd;
    return s;
  endfunction

  function automatic vec_t vx(stim_t s, bit we, logic [4:0] a, logic [31:0] d, bit rdy, bit stl,
                              bit f1v, logic [31:0] f1d, bit f2v, bit bsy);
    vec_t v;
    v.in = s; v.we = we; v.addr = a; v.data = d; v.ready = rdy; v.stall = stl;
    v.f1v = f1v; v.f1d = f1d; v.f2v = f2v; v.busy = bsy;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    alu_valid = s.av; alu_rd = s.ar; alu_data = s.ad;
    lsu_valid = s.lv; lsu_rd = s.lr; lsu_data = s.ld;
    pend_set = s.ps; pend_rd = s.pr;
    dec_rs1 = s.rs1; dec_rs2 = s.rs2; dec_rd = s.drd;
  endtask

  task automatic modelReset();
    m_q.delete();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_we = 1'b0; m_addr = '0; m_data = '0;
  endtask

  task automatic checkOutput();
    bit   any_pend;
    bit   e_stall, e_f1v, e_f2v;
    any_pend = 1'b0;
    foreach (m_pend[i]) any_pend |= m_pend[i];
    e_stall = (dec_rs1 != 0 && m_pend[dec_rs1]) || (dec_rs2 != 0 && m_pend[dec_rs2]) ||
              (dec_rd != 0 && m_pend[dec_rd]);
    e_f1v = m_we && (m_addr == dec_rs1) && (dec_rs1 != 0);
    e_f2v = m_we && (m_addr == dec_rs2) && (dec_rs2 != 0);
    cmp("rd_we", 32'(rd_we), 32'(m_we));
    if (m_we) begin
      cmp("rd_addr", 32'(rd_addr), 32'(m_addr));
      cmp("rd_data", rd_data, m_data);
    end
    cmp("lsu_ready", 32'(lsu_ready), 32'(m_q.size() < DEPTH));
    cmp("hazard_stall", 32'(hazard_stall), 32'(e_stall));
    cmp("rs1_fwd_valid", 32'(rs1_fwd_valid), 32'(e_f1v));
    cmp("rs1_fwd_data", rs1_fwd_data, e_f1v ? m_data : 32'h0);
    cmp("rs2_fwd_valid", 32'(rs2_fwd_valid), 32'(e_f2v));
    cmp("rs2_fwd_data", rs2_fwd_data, e_f2v ? m_data : 32'h0);
    cmp("busy", 32'(busy), 32'(m_q.size() != 0 || any_pend));
  endtask

  task automatic modelStep();
    bit   accept;
    ent_t e;
    accept = lsu_valid && (m_q.size() < DEPTH);
    if (alu_valid) begin
      m_we = (alu_rd != 0); m_addr = alu_rd; m_data = alu_data;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_we = (e.rd != 0); m_addr = e.rd; m_data = e.data;
      m_pend[e.rd] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (accept) begin
      e.rd = lsu_rd; e.data = lsu_data;
      m_q.push_back(e);
    end
    if (pend_set && pend_rd != 0) m_pend[pend_rd] = 1'b1;
  endtask

  task automatic sampleCycle();
    #1;
    checkOutput();
    if (rd_we) wr_log.push_back(rd_addr);
  endtask

  task automatic advance();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic runCycle(input stim_t s);
    applyStimulus(s);
    sampleCycle();
    advance();
  endtask

  stim_t idle;
  logic [4:0] exp_order[7];

  initial begin
    idle = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0]  = vx(st(1, 5, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = vx(st(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0), 1, 5, 32'h12345678, 1, 0, 1, 32'h12345678, 0, 0);
    tbl[2]  = vx(st(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0), 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[3]  = vx(st(0, 0, 0, 0, 0, 0, 1, 7, 0, 7, 0), 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[4]  = vx(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0), 0, 0, 0, 1, 1, 0, 0, 0, 1);
    tbl[5]  = vx(st(0, 0, 0, 1, 7, 32'hDEADBEEF, 0, 0, 0, 7, 0), 0, 0, 0, 1, 1, 0, 0, 0, 1);
    tbl[6]  = vx(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0), 0, 0, 0, 1, 1, 0, 0, 0, 1);
    tbl[7]  = vx(st(0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 0), 1, 7, 32'hDEADBEEF, 1, 0, 1, 32'hDEADBEEF, 1, 0);
    tbl[8]  = vx(st(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0, 0), 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[9]  = vx(idle, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[10] = vx(idle, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[11] = vx(st(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0), 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[12] = vx(st(0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0, 9), 0, 0, 0, 1, 1, 0, 0, 0, 1);
    tbl[13] = vx(st(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 9), 0, 0, 0, 1, 1, 0, 0, 0, 1);
    tbl[14] = vx(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9), 1, 9, 32'h99, 1, 1, 0, 0, 0, 1);
    tbl[15] = vx(st(0, 0, 0, 1, 9, 32'hAA, 0, 0, 0, 0, 9), 0, 0, 0, 1, 1, 0, 0, 0, 1);
    tbl[16] = vx(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9), 0, 0, 0, 1, 1, 0, 0, 0, 1);
    tbl[17] = vx(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9), 1, 9, 32'hAA, 1, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    applyStimulus(idle);
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    cmp("reset rd_we", 32'(rd_we), 0);
    cmp("reset rd_addr", 32'(rd_addr), 0);
    cmp("reset rd_data", rd_data, 0);
    cmp("reset lsu_ready", 32'(lsu_ready), 1);
    cmp("reset busy", 32'(busy), 0);
    cmp("reset hazard_stall", 32'(hazard_stall), 0);
    cmp("reset rs1_fwd_valid", 32'(rs1_fwd_valid), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].in);
      sampleCycle();
      cmp($sformatf("row%0d we", i), 32'(rd_we), 32'(tbl[i].we));
      if (tbl[i].we) begin
        cmp($sformatf("row%0d addr", i), 32'(rd_addr), 32'(tbl[i].addr));
        cmp($sformatf("row%0d data", i), rd_data, tbl[i].data);
      end
      cmp($sformatf("row%0d ready", i), 32'(lsu_ready), 32'(tbl[i].ready));
      cmp($sformatf("row%0d stall", i), 32'(hazard_stall), 32'(tbl[i].stall));
      cmp($sformatf("row%0d f1v", i), 32'(rs1_fwd_valid), 32'(tbl[i].f1v));
      cmp($sformatf("row%0d f1d", i), rs1_fwd_data, tbl[i].f1d);
      cmp($sformatf("row%0d f2v", i), 32'(rs2_fwd_valid), 32'(tbl[i].f2v));
      cmp($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].busy));
      advance();
    end

    $display("[TB] ALU priority with FIFO fill");
    wr_log.delete();
    for (int c = 0; c < 5; c++) begin
      case (c)
        0:       applyStimulus(st(1, 5'(10 + c), 32'(c), 1, 3, 32'h333, 0, 0, 0, 0, 0));
        1:       applyStimulus(st(1, 5'(10 + c), 32'(c), 1, 4, 32'h444, 0, 0, 0, 0, 0));
        default: applyStimulus(st(1, 5'(10 + c), 32'(c), 1, 5, 32'h555, 0, 0, 0, 0, 0));
      endcase
      sampleCycle();
      cmp($sformatf("fill%0d lsu_ready", c), 32'(lsu_ready), (c < 2) ? 32'd1 : 32'd0);
      advance();
    end
    repeat (4) runCycle(idle);
    exp_order = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd4};
    cmp("write count", 32'(wr_log.size()), 7);
    for (int k = 0; k < 7 && k < wr_log.size(); k++)
      cmp($sformatf("write order %0d", k), 32'(wr_log[k]), 32'(exp_order[k]));

    $display("[TB] reset mid-operation");
    runCycle(st(1, 20, 32'h20, 1, 3, 32'h1, 1, 3, 0, 0, 0));
    runCycle(st(1, 21, 32'h21, 1, 4, 32'h2, 0, 0, 0, 0, 0));
    applyStimulus(st(1, 22, 32'h22, 0, 0, 0, 0, 0, 3, 0, 0));
    sampleCycle();
    cmp("pre-reset lsu_ready", 32'(lsu_ready), 0);
    cmp("pre-reset stall", 32'(hazard_stall), 1);
    applyStimulus(st(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
    rst_n = 1'b0;
    #1;
    cmp("mid-reset rd_we", 32'(rd_we), 0);
    cmp("mid-reset busy", 32'(busy), 0);
    cmp("mid-reset lsu_ready", 32'(lsu_ready), 1);
    cmp("mid-reset stall", 32'(hazard_stall), 0);
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_log.delete();
    repeat (4) runCycle(idle);
    cmp("post-reset writes", 32'(wr_log.size()), 0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      runCycle(st($urandom_range(0, 1) == 1 && $urandom_range(0, 2) != 0 ? 1'b0 : 1'b1,
                  5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7))));
    end
    repeat (6) runCycle(idle);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
